// File: rtl/dadda_dot_accumulator.sv
// Multiply-accumulate wrapper around an external 8-bit combinational Dadda multiplier.
// Registers operand pairs onto the multiplier, sums the products and returns the dot product.
module dadda_dot_accumulator #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 24,
  parameter int unsigned LEN_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   len,
  output logic                   busy,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [WIDTH-1:0]       a_in1,
  input  logic [WIDTH-1:0]       a_in2,
  output logic [WIDTH-1:0]       mul_in1,
  output logic [WIDTH-1:0]       mul_in2,
  input  logic [2*WIDTH-1:0]     mul_prod,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ACC_WIDTH-1:0]   res_acc,
  output logic                   res_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state, next_state;
  logic [LEN_WIDTH-1:0]   remaining;
  logic                   p_valid;
  logic [ACC_WIDTH-1:0]   acc;
  logic                   ovf;

  logic                   job_start;
  logic                   take;
  logic [ACC_WIDTH:0]     acc_sum;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b1;
    a_ready    = 1'b0;
    res_valid  = 1'b0;
    job_start  = 1'b0;
    take       = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          job_start  = 1'b1;
          next_state = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        a_ready = 1'b1;
        take    = a_valid;
        if (a_valid && remaining == LEN_WIDTH'(1))
          next_state = DRAIN;
      end
      DRAIN: next_state = DONE;
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // One extra bit catches the carry out of the accumulator MSB for the sticky overflow flag.
  assign acc_sum = {1'b0, acc} + {{(ACC_WIDTH + 1 - 2*WIDTH){1'b0}}, mul_prod};

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      p_valid   <= 1'b0;
      mul_in1   <= '0;
      mul_in2   <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
    end else begin
      p_valid <= take;
      if (job_start) remaining <= len;
      else if (take) remaining <= remaining - LEN_WIDTH'(1);
      if (take) begin
        mul_in1 <= a_in1;
        mul_in2 <= a_in2;
      end
      if (job_start) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (p_valid) begin
        acc <= acc_sum[ACC_WIDTH-1:0];
        if (acc_sum[ACC_WIDTH]) ovf <= 1'b1;
      end
    end
  end

  assign res_acc = acc;
  assign res_ovf = ovf;

endmodule
